nn_infer_ctrl: RTL and testbench

- Top-level inference sequencer for the MNIST datapath.
- Sequencing order:
  - runs layer 1 (48 hidden activations);
  - runs the 10-output layer 2 engine;
  - scans the 10 stored logits through the layer 2 read port;
  - reports the argmax digit.
- Owns all start/done handshakes and a per-layer watchdog.
- Sits between the chip I/O wrapper and the layer engines.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/nn_argmax_scan.sv | 44 ++++
 rtl/nn_infer_ctrl.sv | 158 +++++++++++++++
 tb/tb_nn_infer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and state encoding for the MNIST inference sequencer
package nn_pkg;
  localparam int N_OUT   = 10;
  localparam int LOGIT_W = 6;
  localparam int DIGIT_W = 4;
  localparam int TIMEOUT = 1023;

  localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_RUN,
    ST_L1_REL,
    ST_L2_RUN,
    ST_L2_REL,
    ST_SCAN,
    ST_DONE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/nn_argmax_scan.sv
// rtl/nn_argmax_scan.sv - running signed argmax over logits presented one per cycle
module nn_argmax_scan
  import nn_pkg::*;
#(
  parameter int LOGIT_W = nn_pkg::LOGIT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      en,
  input  logic [DIGIT_W-1:0]        addr,
  input  logic signed [LOGIT_W-1:0] data,
  output logic signed [LOGIT_W-1:0] best,
  output logic [DIGIT_W-1:0]        idx
);
  localparam logic signed [LOGIT_W-1:0] MIN_VAL = {1'b1, {(LOGIT_W-1){1'b0}}};

  logic signed [LOGIT_W-1:0] best_q;
  logic [DIGIT_W-1:0]        idx_q;

  // best/idx already include this cycle's compare so the last logit is
  // folded in on the same cycle it is read.
  always_comb begin
    best = best_q;
    idx  = idx_q;
    if (clear) begin
      best = MIN_VAL;
      idx  = '0;
    end else if (en && (data > best_q)) begin
      best = data;
      idx  = addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= MIN_VAL;
      idx_q  <= '0;
    end else begin
      best_q <= best;
      idx_q  <= idx;
    end
  end
endmodule

// File: rtl/nn_infer_ctrl.sv
// rtl/nn_infer_ctrl.sv - layer 1 / layer 2 sequencing, logit argmax scan and per-phase watchdog
module nn_infer_ctrl
  import nn_pkg::*;
#(
  parameter int N_OUT   = nn_pkg::N_OUT,
  parameter int LOGIT_W = nn_pkg::LOGIT_W,
  parameter int TIMEOUT = nn_pkg::TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      result_valid,
  output logic [DIGIT_W-1:0]        digit,
  output logic signed [LOGIT_W-1:0] best_logit,
  output logic                      error,
  output logic                      l1_start,
  input  logic                      l1_done,
  output logic                      l2_start,
  input  logic                      l2_done,
  output logic [DIGIT_W-1:0]        l2_read_addr,
  input  logic signed [LOGIT_W-1:0] l2_read_data
);
  localparam int                 WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]    WD_LIMIT  = WD_W'(TIMEOUT - 1);
  localparam logic [DIGIT_W-1:0] LAST_ADDR = DIGIT_W'(N_OUT - 1);

  state_t                    state, state_n;
  logic [WD_W-1:0]           wdog, wdog_n;
  logic                      busy_n, rv_n, err_n, l1s_n, l2s_n;
  logic [DIGIT_W-1:0]        digit_n, addr_n;
  logic signed [LOGIT_W-1:0] best_logit_n;
  logic                      scan_clear, scan_en, in_layer;
  logic signed [LOGIT_W-1:0] scan_best;
  logic [DIGIT_W-1:0]        scan_idx;

  nn_argmax_scan #(.LOGIT_W(LOGIT_W)) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (scan_clear),
    .en    (scan_en),
    .addr  (l2_read_addr),
    .data  (l2_read_data),
    .best  (scan_best),
    .idx   (scan_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wdog         <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      l1_start     <= 1'b0;
      l2_start     <= 1'b0;
      digit        <= '0;
      best_logit   <= '0;
      l2_read_addr <= '0;
    end else begin
      state        <= state_n;
      wdog         <= wdog_n;
      busy         <= busy_n;
      result_valid <= rv_n;
      error        <= err_n;
      l1_start     <= l1s_n;
      l2_start     <= l2s_n;
      digit        <= digit_n;
      best_logit   <= best_logit_n;
      l2_read_addr <= addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    busy_n       = busy;
    rv_n         = result_valid;
    err_n        = error;
    l1s_n        = l1_start;
    l2s_n        = l2_start;
    digit_n      = digit;
    best_logit_n = best_logit;
    addr_n       = l2_read_addr;
    wdog_n       = '0;
    scan_clear   = 1'b0;
    scan_en      = 1'b0;
    in_layer     = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_n      = ST_L1_RUN;
          rv_n         = 1'b0;
          err_n        = 1'b0;
          digit_n      = '0;
          best_logit_n = '0;
          busy_n       = 1'b1;
          l1s_n        = 1'b1;
        end
      end
      ST_L1_RUN: begin
        in_layer = 1'b1;
        if (l1_done) begin
          l1s_n   = 1'b0;
          state_n = ST_L1_REL;
        end
      end
      ST_L1_REL: begin
        in_layer = 1'b1;
        if (!l1_done) begin
          l2s_n   = 1'b1;
          state_n = ST_L2_RUN;
        end
      end
      ST_L2_RUN: begin
        in_layer = 1'b1;
        if (l2_done) begin
          l2s_n   = 1'b0;
          state_n = ST_L2_REL;
        end
      end
      ST_L2_REL: begin
        in_layer = 1'b1;
        if (!l2_done) begin
          addr_n     = '0;
          scan_clear = 1'b1;
          state_n    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_en = 1'b1;
        if (l2_read_addr == LAST_ADDR) begin
          digit_n      = scan_idx;
          best_logit_n = scan_best;
          rv_n         = 1'b1;
          busy_n       = 1'b0;
          state_n      = ST_DONE;
        end else begin
          addr_n = l2_read_addr + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Watchdog restarts on every phase change; a stalled phase gets TIMEOUT cycles.
    if (in_layer && (state_n == state)) begin
      if (wdog == WD_LIMIT) begin
        state_n = ST_ERR;
        l1s_n   = 1'b0;
        l2s_n   = 1'b0;
        busy_n  = 1'b0;
        err_n   = 1'b1;
      end else begin
        wdog_n = wdog + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nn_infer_ctrl.sv
// tb/tb_nn_infer_ctrl.sv - randomized scoreboard bench for nn_infer_ctrl with layer engine stubs
module tb_nn_infer_ctrl;
  localparam int N_OUT   = 10;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, result_valid, error;
  logic [3:0]        digit;
  logic signed [5:0] best_logit;
  logic              l1_start, l1_done, l2_start, l2_done;
  logic [3:0]        l2_read_addr;
  logic signed [5:0] l2_read_data;

  int errors = 0;
  int checks = 0;
  int logits[N_OUT];
  int l1_lat = 1, l2_lat = 1;
  bit l2_hang = 1'b0;
  int cyc = 0;
  int drop_cyc = 0;

  typedef struct {
    bit err;
    int digit;
    int best;
  } exp_t;
  exp_t exp_q[$];

  nn_infer_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .digit        (digit),
    .best_logit   (best_logit),
    .error        (error),
    .l1_start     (l1_start),
    .l1_done      (l1_done),
    .l2_start     (l2_start),
    .l2_done      (l2_done),
    .l2_read_addr (l2_read_addr),
    .l2_read_data (l2_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign l2_read_data = (int'(l2_read_addr) < N_OUT) ? 6'(logits[l2_read_addr]) : 6'sd0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the largest logit, reported at the first position holding it.
  function automatic exp_t model();
    exp_t e;
    int mx = logits[0];
    for (int i = 1; i < N_OUT; i++) if (logits[i] > mx) mx = logits[i];
    e.err = 1'b0;
    e.best = mx;
    e.digit = -1;
    for (int i = 0; i < N_OUT; i++) if (logits[i] == mx && e.digit < 0) e.digit = i;
    return e;
  endfunction

  // Layer engine stubs: done after a latency, released only once start falls.
  initial begin
    int c1 = 0, c2 = 0;
    l1_done = 1'b0;
    l2_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c1 = 0; c2 = 0; l1_done = 1'b0; l2_done = 1'b0;
      end else begin
        if (l1_start) begin
          c1++;
          if (c1 >= l1_lat) l1_done = 1'b1;
        end else begin
          c1 = 0; l1_done = 1'b0;
        end
        if (l2_start) begin
          c2++;
          if (c2 >= l2_lat && !l2_hang) l2_done = 1'b1;
        end else begin
          if (l2_done) drop_cyc = cyc;
          c2 = 0; l2_done = 1'b0;
        end
      end
    end
  end

  initial begin
    bit prv_rv = 1'b0, prv_err = 1'b0;
    int l2_run = 0, l2_last = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv_rv = 1'b0; prv_err = 1'b0; l2_run = 0;
        continue;
      end
      if (l2_start) l2_run++;
      else if (l2_run != 0) begin
        l2_last = l2_run; l2_run = 0;
      end
      if ((result_valid && !prv_rv) || (error && !prv_err)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got digit %0d error %0d expected no result", digit, error);
        end else begin
          e = exp_q.pop_front();
          chk("error_flag", error, e.err);
          chk("busy_at_end", busy, 0);
          if (e.err) begin
            chk("l1_start_in_err", l1_start, 0);
            chk("l2_start_in_err", l2_start, 0);
            chk("result_valid_in_err", result_valid, 0);
            chk("l2_phase_cycles", l2_last, TIMEOUT);
          end else begin
            chk("digit", digit, e.digit);
            chk("best_logit", best_logit, e.best);
            chk("scan_latency", cyc - drop_cyc, N_OUT + 1);
          end
        end
      end
      prv_rv = result_valid;
      prv_err = error;
    end
  end

  task automatic issue(input bit push, input bit is_err);
    exp_t e;
    if (push) begin
      if (is_err) begin
        e.err = 1'b1; e.digit = 0; e.best = 0;
      end else e = model();
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_sig(input string name, input bit want_l2, input int addr);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 5000) begin
      @(negedge clk);
      n++;
      if (want_l2) hit = l2_start;
      else hit = !l2_start && busy && int'(l2_read_addr) == addr;
    end
    chk(name, hit, 1);
  endtask

  task automatic rand_logits();
    for (int i = 0; i < N_OUT; i++) logits[i] = int'($urandom_range(63)) - 32;
    if ($urandom_range(1)) logits[$urandom_range(N_OUT - 1)] = logits[$urandom_range(N_OUT - 1)];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_best_logit"}, best_logit, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_l1_start"}, l1_start, 0);
    chk({tag, "_l2_start"}, l2_start, 0);
    chk({tag, "_l2_read_addr"}, l2_read_addr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N_OUT; i++) logits[i] = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    logits = '{3, -5, 12, 7, 12, 0, -32, 1, 9, 11};
    l1_lat = 100; l2_lat = 520;
    issue(1, 0);
    chk("busy_after_accept", busy, 1);
    chk("l1_start_after_accept", l1_start, 1);
    wait_idle("idle_normal");
    chk("result_valid_held", result_valid, 1);

    l1_lat = 5; l2_lat = 7;
    for (int i = 0; i < N_OUT; i++) logits[i] = -32;
    issue(1, 0); wait_idle("idle_all_min");
    for (int i = 0; i < N_OUT; i++) logits[i] = 31;
    issue(1, 0); wait_idle("idle_all_max");
    for (int i = 0; i < N_OUT; i++) logits[i] = -1;
    logits[N_OUT - 1] = 31;
    issue(1, 0); wait_idle("idle_last_idx");

    l2_hang = 1'b1;
    issue(1, 1); wait_idle("idle_timeout");
    chk("error_held", error, 1);
    l2_hang = 1'b0;
    logits = '{3, -5, 12, 7, 12, 0, -32, 1, 9, 11};
    issue(1, 0);
    chk("error_cleared_on_accept", error, 0);
    wait_idle("idle_recover");

    l1_lat = 700; l2_lat = 700;
    rand_logits();
    issue(1, 0); wait_idle("idle_long_phases");

    l1_lat = 20; l2_lat = 40;
    rand_logits();
    issue(1, 0);
    wait_sig("reach_l2_run", 1'b1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("idle_start_ignored");

    rand_logits();
    l1_lat = 3; l2_lat = 4;
    exp_q.push_back(model());
    exp_q.push_back(model());
    start = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!result_valid && n < 5000);
      chk("held_first_result", result_valid, 1);
    end
    @(negedge clk);
    chk("held_rv_cleared", result_valid, 0);
    chk("held_busy_again", busy, 1);
    start = 1'b0;
    wait_idle("idle_held");

    rand_logits();
    l1_lat = 10; l2_lat = 10;
    issue(0, 0);
    wait_sig("abort_reach_l2", 1'b1, 0);
    wait_sig("abort_reach_addr4", 1'b0, 4);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midscan_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_logits();
    issue(1, 0); wait_idle("idle_after_reset");

    for (int r = 0; r < 10; r++) begin
      rand_logits();
      l1_lat = int'($urandom_range(1, 30));
      l2_lat = int'($urandom_range(1, 30));
      issue(1, 0);
      wait_idle("idle_random");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
